// File: rtl/bp_common_cfg_link_pkg.sv
// Shared definitions for the config-link loader: processor configs, register ids,
// loader FSM states and the write-sequence table.
package bp_common_cfg_link_pkg;

    typedef enum logic [1:0] {
        e_bp_single_core_cfg = 2'd0,
        e_bp_dual_core_cfg   = 2'd1,
        e_bp_quad_core_cfg   = 2'd2,
        e_bp_oct_core_cfg    = 2'd3
    } bp_params_e;

    typedef struct packed {
        logic [7:0] num_core;
    } bp_proc_param_s;

    localparam bp_proc_param_s all_cfgs_gp [4] = '{
        '{num_core: 8'd1},
        '{num_core: 8'd2},
        '{num_core: 8'd4},
        '{num_core: 8'd8}
    };

    localparam logic [7:0] cfg_reg_freeze_gp      = 8'h01;
    localparam logic [7:0] cfg_reg_core_id_gp     = 8'h02;
    localparam logic [7:0] cfg_reg_icache_mode_gp = 8'h03;
    localparam logic [7:0] cfg_reg_dcache_mode_gp = 8'h04;

    typedef enum logic [2:0] {
        e_reset    = 3'd0,
        e_send     = 3'd1,
        e_drain    = 3'd2,
        e_readback = 3'd3,
        e_done     = 3'd4
    } bp_cfg_loader_state_e;

    localparam logic [2:0] cfg_last_entry_gp = 3'd4;

    // Per-core sequence: freeze, core id, icache mode, dcache mode, unfreeze.
    function automatic logic [7:0] cfg_entry_reg(input logic [2:0] entry);
        logic [7:0] id;
        case (entry)
            3'd1:    id = cfg_reg_core_id_gp;
            3'd2:    id = cfg_reg_icache_mode_gp;
            3'd3:    id = cfg_reg_dcache_mode_gp;
            default: id = cfg_reg_freeze_gp;
        endcase
        return id;
    endfunction

    function automatic logic [7:0] cfg_entry_data(input logic [2:0] entry, input logic [7:0] core);
        logic [7:0] d;
        case (entry)
            3'd0, 3'd2, 3'd3: d = 8'd1;
            3'd1:             d = core;
            default:          d = 8'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// Up/down occupancy counter used to track outstanding config commands.
module bsg_counter_up_down #(
    parameter int max_val_p = 4,
    parameter int width_p   = $clog2(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q;
    logic [width_p-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (up_i && !down_i) begin
            count_d = count_q + 1'b1;
        end else if (down_i && !up_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_cfg_stream_loader.sv
// Streams the per-core boot configuration writes with credit flow control.
// Optional readback of each core id is enabled by defining BP_CFG_LOADER_READBACK_EN.
module bp_cfg_stream_loader
    import bp_common_cfg_link_pkg::*;
#(
    parameter bp_params_e bp_params_p      = e_bp_single_core_cfg,
    parameter int         cfg_addr_width_p = 16,
    parameter int         cfg_data_width_p = 32,
    parameter int         max_credits_p    = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic                        cfg_v_o,
    output logic                        cfg_w_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_ready_i,
    input  logic                        cfg_resp_v_i,
    input  logic [cfg_data_width_p-1:0] cfg_resp_data_i,
    output logic                        done_o,
    output logic                        error_o
);

    localparam int num_core_lp     = int'(all_cfgs_gp[bp_params_p].num_core);
    localparam int core_width_lp   = (num_core_lp > 1) ? $clog2(num_core_lp) : 1;
    localparam int credit_width_lp = $clog2(max_credits_p + 1);
    localparam logic [core_width_lp-1:0] last_core_lp = core_width_lp'(num_core_lp - 1);

    bp_cfg_loader_state_e       state_q, state_d;
    logic [2:0]                 entry_q, entry_d;
    logic [core_width_lp-1:0]   core_q, core_d;
    logic [credit_width_lp-1:0] credit_count;
    logic                       credit_full, credit_empty;
    logic                       cmd_v, cmd_active, handshake, resp_accept;
    logic [7:0]                 reg_id, wdata;

    assign credit_full  = (credit_count == credit_width_lp'(max_credits_p));
    assign credit_empty = (credit_count == '0);
    assign handshake    = cfg_v_o & cfg_ready_i;
    // A response with nothing outstanding is dropped so the counter cannot underflow.
    assign resp_accept  = cfg_resp_v_i & ~credit_empty;

    bsg_counter_up_down #(
        .max_val_p(max_credits_p),
        .width_p  (credit_width_lp)
    ) u_credits (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .up_i   (handshake),
        .down_i (resp_accept),
        .count_o(credit_count)
    );

    always_comb begin
        cmd_v = 1'b0;
        case (state_q)
            e_send:     cmd_v = ~credit_full;
`ifdef BP_CFG_LOADER_READBACK_EN
            e_readback: cmd_v = credit_empty;
`endif
            default:    cmd_v = 1'b0;
        endcase
    end

    assign cmd_active = (state_q == e_send) || (state_q == e_readback);
    assign reg_id = (state_q == e_readback) ? cfg_reg_core_id_gp : cfg_entry_reg(entry_q);
    assign wdata  = (state_q == e_readback) ? 8'd0 : cfg_entry_data(entry_q, 8'(core_q));

    // Outputs are forced to their idle values combinationally for the whole reset window.
    assign cfg_v_o    = cmd_v & ~reset_i;
    assign cfg_addr_o = (cmd_active && !reset_i)
                      ? ((cfg_addr_width_p'(core_q) << 8) | cfg_addr_width_p'(reg_id)) : '0;
    assign cfg_data_o = (cmd_active && !reset_i) ? cfg_data_width_p'(wdata) : '0;
    assign done_o     = (state_q == e_done) & ~reset_i;

`ifdef BP_CFG_LOADER_READBACK_EN
    logic error_q, error_d;
    assign cfg_w_o = (state_q == e_send) & ~reset_i;
    assign error_o = error_q & ~reset_i;
`else
    logic unused_resp_data;
    assign unused_resp_data = ^cfg_resp_data_i;
    assign cfg_w_o = ~reset_i;
    assign error_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        core_d  = core_q;
`ifdef BP_CFG_LOADER_READBACK_EN
        error_d = error_q;
`endif
        case (state_q)
            e_reset: state_d = e_send;
            e_send: begin
                if (handshake) begin
                    if (entry_q == cfg_last_entry_gp) begin
                        entry_d = '0;
                        if (core_q == last_core_lp) begin
                            core_d  = '0;
                            state_d = e_drain;
                        end else begin
                            core_d = core_q + 1'b1;
                        end
                    end else begin
                        entry_d = entry_q + 3'd1;
                    end
                end
            end
            e_drain: begin
                if (credit_empty) begin
`ifdef BP_CFG_LOADER_READBACK_EN
                    state_d = e_readback;
`else
                    state_d = e_done;
`endif
                end
            end
`ifdef BP_CFG_LOADER_READBACK_EN
            e_readback: begin
                if (resp_accept) begin
                    if (cfg_resp_data_i != cfg_data_width_p'(core_q)) begin
                        error_d = 1'b1;
                    end
                    if (core_q == last_core_lp) begin
                        state_d = e_done;
                    end else begin
                        core_d = core_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_reset;
            entry_q <= '0;
            core_q  <= '0;
`ifdef BP_CFG_LOADER_READBACK_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            core_q  <= core_d;
`ifdef BP_CFG_LOADER_READBACK_EN
            error_q <= error_d;
`endif
        end
    end

endmodule

// File: doc/bp_cfg_stream_loader.md
BP_CFG_STREAM_LOADER -- requirements
Module: bp_cfg_stream_loader

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_single_core_cfg, selecting the processor config from all_cfgs_gp (num_core used).
REQ-002 SHALL have parameter cfg_addr_width_p, default 16, config write address width.
REQ-003 SHALL have parameter cfg_data_width_p, default 32, config write data width.
REQ-004 SHALL have parameter max_credits_p, default 4, max outstanding config writes.
REQ-005 SHALL have port clk_i  input  1  sole clock.
REQ-006 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cfg_v_o  output  1  config command valid.
REQ-008 SHALL have port cfg_w_o  output  1  1=write, 0=read.
REQ-009 SHALL have port cfg_addr_o  output  cfg_addr_width_p  {core index, 8-bit register id}, core index in the upper bits.
REQ-010 SHALL have port cfg_data_o  output  cfg_data_width_p  write data.
REQ-011 SHALL have port cfg_ready_i  input  1  receiver accepts command.
REQ-012 SHALL have port cfg_resp_v_i  input  1  one response per accepted command.
REQ-013 SHALL have port cfg_resp_data_i  input  cfg_data_width_p  read response data.
REQ-014 SHALL have port done_o  output  1  sequence complete.
REQ-015 SHALL have port error_o  output  1  readback mismatch (sticky).

Function
REQ-016 SHALL issue, per core c = 0..num_core-1, five writes in this order: reg 0x01 data 1 (freeze); reg 0x02 data c (core id); reg 0x03 data 1 (icache mode); reg 0x04 data 1 (dcache mode); reg 0x01 data 0 (unfreeze).
REQ-017 SHALL use the FSM e_reset -> e_send -> e_drain -> (e_readback ->) e_done.
REQ-018 SHALL leave e_reset one cycle after reset_i deasserts.
REQ-019 SHALL in e_send hold cfg_v_o=1 and the command stable until cfg_v_o & cfg_ready_i (handshake); a command SHALL advance only on handshake.
REQ-020 SHALL hold cfg_v_o=0 while the credit counter equals max_credits_p.
REQ-021 SHALL increment the credit counter on handshake and decrement it on cfg_resp_v_i; a simultaneous handshake and response SHALL leave the count unchanged.
REQ-022 SHALL go from e_send to e_drain after the last command's handshake, and from e_drain to the next state when the counter is 0.
REQ-023 SHALL use an entry counter (0..4) and a core counter; the entry counter SHALL wrap to 0 and the core counter SHALL increment when the unfreeze of core c is accepted.
REQ-024 SHALL drive done_o=1 only in e_done; e_done SHALL be absorbing until reset.
REQ-025 SHALL ignore cfg_resp_v_i when the counter is 0 (no underflow); in that case the counter SHALL stay at 0.
REQ-026 SHALL issue the first command in the second cycle after reset deassertion, with the minimum latency of one cycle per accepted command when cfg_ready_i is held high and credits are available.

Reset
REQ-027 SHALL, while reset_i=1, drive cfg_v_o=0, cfg_w_o=0, cfg_addr_o=0, cfg_data_o=0, done_o=0, error_o=0, state=e_reset, and all counters 0.
REQ-028 SHALL abandon any in-flight sequence and outstanding credits when reset_i asserts mid-operation, and SHALL restart from core 0 entry 0.

Configuration
REQ-029 SHALL, with BP_CFG_LOADER_READBACK_EN defined, enter e_readback after e_drain, issue one read (cfg_w_o=0) of reg 0x02 per core with one outstanding at a time, and set error_o if cfg_resp_data_i != c.
REQ-030 SHALL, without BP_CFG_LOADER_READBACK_EN, go from e_drain directly to e_done, with cfg_w_o tied to 1 and error_o tied to 0.

Structure
REQ-031 SHALL place the register-id constants (freeze, core_id, icache_mode, dcache_mode) and the FSM state enum in the shared package bp_common_cfg_link_pkg.
REQ-032 SHALL use one sub-module, bsg_counter_up_down, for the credit counter.

Verification
REQ-033 SHALL check the single core config with cfg_ready_i=1 and a 1-cycle response: exactly 5 writes (0x0001/1, 0x0002/0, 0x0003/1, 0x0004/1, 0x0001/0), then done_o=1.
REQ-034 SHALL check the dual core config: 10 writes, the second core's addresses 0x01xx, and core-id data 1.
REQ-035 SHALL check backpressure with cfg_ready_i low for 3 cycles on entry 2: the command is held stable and no entry is skipped.
REQ-036 SHALL check responses withheld: cfg_v_o drops after 4 handshakes and resumes on the first cfg_resp_v_i.
REQ-037 SHALL check reset_i pulsed after 3 handshakes: outputs return to their reset values and the sequence restarts at 0x0001/1.
REQ-038 SHALL check, with BP_CFG_LOADER_READBACK_EN, a readback returning 5 for core 0: error_o=1 and done_o=1 after completion.
